// File: rtl/nibble_serial_adder_if.sv
// nibble_serial_adder_if: request, result and 4-bit adder signals of the nibble-serial adder
interface nibble_serial_adder_if #(parameter int WIDTH = 16);
  logic in_valid, in_ready, in_sub, in_cin;
  logic [WIDTH-1:0] in_a, in_b, out_sum;
  logic out_valid, out_ready, out_cout, out_ovf;
  logic [3:0] add_a, add_b, add_sum;
  logic add_ci, add_co;
  modport master (
    output in_valid, in_a, in_b, in_sub, in_cin, out_ready, add_sum, add_co,
    input in_ready, out_valid, out_sum, out_cout, out_ovf, add_a, add_b, add_ci
  );
  modport slave (
    input in_valid, in_a, in_b, in_sub, in_cin, out_ready, add_sum, add_co,
    output in_ready, out_valid, out_sum, out_cout, out_ovf, add_a, add_b, add_ci
  );
endinterface

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: WIDTH-bit add/sub streamed nibble by nibble through an external 4-bit adder
module nibble_serial_adder #(parameter int WIDTH = 16) (
  input logic clk,
  input logic rst_n,
  nibble_serial_adder_if.slave bus
);
  localparam int NIB = WIDTH / 4;
  localparam int CW = NIB > 1 ? $clog2(NIB) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] opa, opb, result, res_n, sum_q;
  logic [CW-1:0] cnt;
  logic [CW+1:0] base;
  logic carry, cout_q, ovf_q, run, last;
  assign base = {cnt, 2'b00};
  assign run = state == RUN;
  assign last = cnt == CW'(NIB - 1);
  assign bus.in_ready = state == IDLE;
  assign bus.out_valid = state == DONE;
  assign bus.add_a = run ? opa[base +: 4] : 4'h0;
  assign bus.add_b = run ? opb[base +: 4] : 4'h0;
  assign bus.add_ci = run & carry;
  assign bus.out_sum = sum_q;
  assign bus.out_cout = cout_q;
  assign bus.out_ovf = ovf_q;
  always_comb begin
    res_n = result;
    res_n[base +: 4] = bus.add_sum;
    state_n = state == IDLE ? (bus.in_valid ? RUN : IDLE) :
              state == RUN  ? (last ? DONE : RUN) :
                              (bus.out_ready ? IDLE : DONE);
  end
  // Published outputs live in their own registers so they hold the last result through IDLE/RUN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      opa <= '0;
      opb <= '0;
      result <= '0;
      sum_q <= '0;
      cnt <= '0;
      carry <= 1'b0;
      cout_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && bus.in_valid) begin
        opa <= bus.in_a;
        opb <= bus.in_sub ? ~bus.in_b : bus.in_b;
        carry <= bus.in_sub | bus.in_cin;
        cnt <= '0;
      end else if (run) begin
        result <= res_n;
        carry <= bus.add_co;
        cnt <= cnt + 1'b1;
        if (last) begin
          sum_q <= res_n;
          cout_q <= bus.add_co;
          ovf_q <= bus.add_sum[3] ^ bus.add_a[3] ^ bus.add_b[3] ^ bus.add_co;
        end
      end
    end
  end
endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb_nibble_serial_adder: directed checks of the nibble-serial adder with a behavioural 4-bit adder
module tb_nibble_serial_adder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int nvec = 0;
  int nerr = 0;
  int cyc = 0;
  typedef struct packed {
    logic [15:0] a, b;
    logic sub, cin;
    logic [15:0] s;
    logic co, ov;
  } vec_t;
  always #5 clk = ~clk;
  nibble_serial_adder_if #(.WIDTH(16)) bus ();
  nibble_serial_adder #(.WIDTH(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  assign {bus.add_co, bus.add_sum} = 5'(bus.add_a) + 5'(bus.add_b) + 5'(bus.add_ci);

  task tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task start_op(input logic [15:0] a, input logic [15:0] b, input logic sub, input logic cin);
    bus.in_a = a;
    bus.in_b = b;
    bus.in_sub = sub;
    bus.in_cin = cin;
    bus.in_valid = 1'b1;
    tick;
    bus.in_valid = 1'b0;
  endtask

  task wait_valid(output int n);
    n = 0;
    while (!bus.out_valid && n < 20) begin
      tick;
      n++;
    end
  endtask

  task test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    nvec++; if (bus.in_ready !== 1'b1) begin nerr++; $display("FAIL rst_in_ready: got %b want 1", bus.in_ready); end
    nvec++; if (bus.out_valid !== 1'b0) begin nerr++; $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); end
    nvec++; if (bus.out_sum !== 16'h0) begin nerr++; $display("FAIL rst_out_sum: got %h want 0000", bus.out_sum); end
    nvec++; if ({bus.out_cout, bus.out_ovf} !== 2'b00) begin nerr++; $display("FAIL rst_cout_ovf: got %b want 00", {bus.out_cout, bus.out_ovf}); end
    nvec++; if ({bus.add_a, bus.add_b, bus.add_ci} !== 9'h0) begin nerr++; $display("FAIL rst_adder_in: got %h want 000", {bus.add_a, bus.add_b, bus.add_ci}); end
    #2 rst_n = 1'b1;
    tick;
    nvec++; if ({bus.in_ready, bus.out_valid} !== 2'b10) begin nerr++; $display("FAIL rst_release: got %b want 10", {bus.in_ready, bus.out_valid}); end
  endtask

  task test_add_ripple;
    logic [3:0] ci;
    start_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      ci[i] = bus.add_ci;
      tick;
    end
    nvec++; if (ci !== 4'b1110) begin nerr++; $display("FAIL ripple_ci_seq: got %b want 1110", ci); end
    nvec++; if (bus.out_valid !== 1'b1) begin nerr++; $display("FAIL ripple_latency: out_valid got %b want 1", bus.out_valid); end
    nvec++; if (bus.out_sum !== 16'h0000) begin nerr++; $display("FAIL ripple_sum: got %h want 0000", bus.out_sum); end
    nvec++; if ({bus.out_cout, bus.out_ovf} !== 2'b10) begin nerr++; $display("FAIL ripple_cout_ovf: got %b want 10", {bus.out_cout, bus.out_ovf}); end
    bus.out_ready = 1'b1;
    tick;
    bus.out_ready = 1'b0;
    nvec++; if ({bus.in_ready, bus.out_valid} !== 2'b10) begin nerr++; $display("FAIL ripple_release: got %b want 10", {bus.in_ready, bus.out_valid}); end
  endtask

  task test_arith;
    vec_t v [6];
    int n;
    v[0] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    v[1] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    v[2] = '{16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0};
    v[3] = '{16'h1234, 16'h0234, 1'b1, 1'b1, 16'h1000, 1'b1, 1'b0};
    v[4] = '{16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1};
    v[5] = '{16'h00FF, 16'h0000, 1'b0, 1'b1, 16'h0100, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++) begin
      start_op(v[i].a, v[i].b, v[i].sub, v[i].cin);
      wait_valid(n);
      nvec++; if (n !== 4) begin nerr++; $display("FAIL arith%0d_latency: got %0d want 4", i, n); end
      nvec++; if (bus.out_sum !== v[i].s) begin nerr++; $display("FAIL arith%0d_sum: got %h want %h", i, bus.out_sum, v[i].s); end
      nvec++; if ({bus.out_cout, bus.out_ovf} !== {v[i].co, v[i].ov}) begin nerr++; $display("FAIL arith%0d_cout_ovf: got %b want %b", i, {bus.out_cout, bus.out_ovf}, {v[i].co, v[i].ov}); end
      bus.out_ready = 1'b1;
      tick;
      bus.out_ready = 1'b0;
    end
  endtask

  task test_backpressure;
    int n;
    start_op(16'h1111, 16'h2222, 1'b0, 1'b0);
    wait_valid(n);
    for (int i = 0; i < 3; i++) begin
      bus.in_a = 16'hFFFF;
      bus.in_b = 16'hFFFF;
      bus.in_valid = 1'b1;
      tick;
      nvec++; if ({bus.out_valid, bus.in_ready} !== 2'b10) begin nerr++; $display("FAIL bp%0d_hs: got %b want 10", i, {bus.out_valid, bus.in_ready}); end
      nvec++; if ({bus.out_sum, bus.out_cout, bus.out_ovf} !== {16'h3333, 2'b00}) begin nerr++; $display("FAIL bp%0d_hold: got %h want %h", i, {bus.out_sum, bus.out_cout, bus.out_ovf}, {16'h3333, 2'b00}); end
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    tick;
    bus.out_ready = 1'b0;
    nvec++; if ({bus.in_ready, bus.out_valid} !== 2'b10) begin nerr++; $display("FAIL bp_release: got %b want 10", {bus.in_ready, bus.out_valid}); end
    tick;
    nvec++; if (bus.in_ready !== 1'b1) begin nerr++; $display("FAIL bp_ignored_req: in_ready got %b want 1", bus.in_ready); end
    nvec++; if (bus.out_sum !== 16'h3333) begin nerr++; $display("FAIL bp_idle_hold: got %h want 3333", bus.out_sum); end
  endtask

  task test_reset_mid_run;
    int n;
    logic seen;
    start_op(16'h0F0F, 16'h0101, 1'b0, 1'b0);
    tick;
    rst_n = 1'b0;
    #1;
    nvec++; if ({bus.in_ready, bus.out_valid} !== 2'b10) begin nerr++; $display("FAIL mid_rst_hs: got %b want 10", {bus.in_ready, bus.out_valid}); end
    nvec++; if ({bus.out_sum, bus.add_a, bus.add_ci} !== 21'h0) begin nerr++; $display("FAIL mid_rst_clear: got %h want 0", {bus.out_sum, bus.add_a, bus.add_ci}); end
    #2 rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick;
      seen |= bus.out_valid;
    end
    nvec++; if (seen !== 1'b0) begin nerr++; $display("FAIL mid_rst_no_valid: got %b want 0", seen); end
    start_op(16'h0F0F, 16'h0101, 1'b0, 1'b0);
    wait_valid(n);
    nvec++; if (n !== 4) begin nerr++; $display("FAIL mid_rst_latency: got %0d want 4", n); end
    nvec++; if (bus.out_sum !== 16'h1010) begin nerr++; $display("FAIL mid_rst_sum: got %h want 1010", bus.out_sum); end
    bus.out_ready = 1'b1;
    tick;
    bus.out_ready = 1'b0;
  endtask

  task test_back_to_back;
    logic [15:0] a [3] = '{16'h00FF, 16'hABCD, 16'h0003};
    logic [15:0] b [3] = '{16'h0000, 16'h1111, 16'h0001};
    logic [15:0] s [3] = '{16'h0100, 16'hBCDE, 16'h0002};
    logic sub [3] = '{1'b0, 1'b0, 1'b1};
    logic cin [3] = '{1'b1, 1'b0, 1'b0};
    logic co [3] = '{1'b0, 1'b0, 1'b1};
    int acc [3];
    int n;
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.in_a = a[i];
      bus.in_b = b[i];
      bus.in_sub = sub[i];
      bus.in_cin = cin[i];
      n = 0;
      while (!bus.in_ready && n < 20) begin
        tick;
        n++;
      end
      acc[i] = cyc;
      tick;
      wait_valid(n);
      nvec++; if (n !== 4) begin nerr++; $display("FAIL b2b%0d_latency: got %0d want 4", i, n); end
      nvec++; if ({bus.out_sum, bus.out_cout} !== {s[i], co[i]}) begin nerr++; $display("FAIL b2b%0d_result: got %h want %h", i, {bus.out_sum, bus.out_cout}, {s[i], co[i]}); end
    end
    bus.in_valid = 1'b0;
    tick;
    bus.out_ready = 1'b0;
    nvec++; if (acc[1] - acc[0] !== 6) begin nerr++; $display("FAIL b2b_gap01: got %0d want 6", acc[1] - acc[0]); end
    nvec++; if (acc[2] - acc[1] !== 6) begin nerr++; $display("FAIL b2b_gap12: got %0d want 6", acc[2] - acc[1]); end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_a = '0;
    bus.in_b = '0;
    bus.in_sub = 1'b0;
    bus.in_cin = 1'b0;
    bus.out_ready = 1'b0;
    test_reset;
    test_add_ripple;
    test_arith;
    test_backpressure;
    test_reset_mid_run;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/nibble_serial_adder.md
# nibble_serial_adder

Sequencer that performs WIDTH-bit add/subtract operations by streaming operands through the team's 4-bit ripple adder one nibble per cycle. It sits directly upstream of the 4-bit adder and also consumes that adder's result. The block drives the adder's A/B/CI inputs from registered operand slices and captures its SUM/CO into a result shift register. It presents valid/ready handshakes on both the request side and the result side.

## Interface
- WIDTH, 16, operand width in bits; must be a multiple of 4 and at least 4; NIB = WIDTH/4
- clk  in  1  clock; all state changes on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  request valid
- in_ready  out  1  block can accept a request
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B
- in_sub  in  1  1 = A − B, 0 = A + B
- in_cin  in  1  carry-in for add; ignored when in_sub=1
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_sum  out  WIDTH  result
- out_cout  out  1  carry out of bit WIDTH−1
- out_ovf  out  1  signed two's-complement overflow
- add_a  out  4  to adder A
- add_b  out  4  to adder B
- add_ci  out  1  to adder CI
- add_sum  in  4  from adder SUM
- add_co  in  1  from adder CO

## Operation
- States: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid, latch the operands: opa=in_a; opb = in_sub ? ~in_b : in_b; carry = in_sub ? 1 : in_cin; nibble counter cnt=0. Go to RUN.
- RUN:
  - Combinationally drive add_a=opa[4cnt+3:4cnt], add_b=opb[4cnt+3:4cnt], add_ci=carry.
  - Each edge: write add_sum into result bits [4cnt+3:4cnt]; carry←add_co; cnt←cnt+1.
  - On the edge where cnt=NIB−1, also record msb_cin = add_sum[3]^add_a[3]^add_b[3] (carry into bit WIDTH−1), then go to DONE.
- DONE:
  - out_valid=1; out_sum=result; out_cout=carry; out_ovf=msb_cin^carry.
  - On out_ready, go to IDLE.
- Outside RUN, add_a, add_b and add_ci are driven to 0.
- in_ready=0 in RUN and DONE. Requests are not queued.
- out_sum, out_cout and out_ovf are held stable, and unchanged, while out_valid=1 and out_ready=0.
- In IDLE and RUN, out_sum/out_cout/out_ovf hold the previous result (0 after reset). Only out_valid qualifies them.
- Arithmetic is modulo 2^WIDTH. For subtract, out_cout=1 means no borrow (A ≥ B unsigned).

## Timing
- Reset (asynchronous on rst_n low): state=IDLE, cnt=0, result=0, carry=0, msb_cin=0. Outputs: in_ready=1, out_valid=0, out_sum=0, out_cout=0, out_ovf=0, add_a=0, add_b=0, add_ci=0.
- Reset asserted mid-RUN or in DONE aborts the operation immediately; the result is discarded.
- Request accepted at edge E0 (in_valid & in_ready). RUN occupies cycles E0..E0+NIB−1. out_valid rises after edge E0+NIB, i.e. a latency of NIB cycles (4 for WIDTH=16).
- The DONE→IDLE edge lowers out_valid and raises in_ready. The earliest next accept is the following edge, so maximum throughput is one operation per NIB+2 cycles.
- The adder path is purely combinational within one cycle: add_a/add_b/add_ci are stable from state registers, and add_sum/add_co are sampled at the next edge.
- WIDTH=4 edge case: a single RUN cycle; msb_cin is taken from that cycle.

## Test plan
- Reset check: hold rst_n low, then release → in_ready=1, out_valid=0, all outputs 0. Pulse rst_n low during the 2nd RUN cycle → immediate IDLE, out_valid never rises, and the next request completes correctly.
- Add with carry ripple, WIDTH=16: A=0xFFFF, B=0x0001, sub=0, cin=0 → after 4 cycles out_sum=0x0000, out_cout=1, out_ovf=0. add_ci per RUN cycle must be 0,1,1,1.
- Signed overflow: A=0x7FFF, B=0x0001, add → out_sum=0x8000, out_cout=0, out_ovf=1. Also A=0x8000, B=0x8000 → out_sum=0x0000, out_cout=1, out_ovf=1.
- Subtract: A=0x0005, B=0x0007, sub=1 → out_sum=0xFFFE, out_cout=0, out_ovf=0. A=0x1234, B=0x0234, sub=1 → out_sum=0x1000, out_cout=1.
- Backpressure: hold out_ready=0 for 3 cycles after out_valid → outputs stable, in_ready=0, a new in_valid is ignored. Raise out_ready → IDLE on the next edge, in_ready=1.
- Back-to-back: keep in_valid=1 and out_ready=1 with 3 queued operations → each accepted exactly NIB+2 cycles apart, results in order, carry-in reused correctly (cin=1: 0x00FF+0x0000 → 0x0100).
